sram_byte_loader: RTL and testbench
===================================

SRAM_BYTE_LOADER -- requirements
Module: sram_byte_loader

Interface
REQ-001 Parameter ADDR_W, default 16, SRAM byte-address width.
REQ-002 Parameter COEF_BASE, default 16'h0000, byte address of coefficient set 0.
REQ-003 Parameter COEF_SET_BYTES, default 16, bytes per coefficient set.
REQ-004 Parameter IMAGE_BASE, default 16'h4000, byte address of image data.
REQ-005 Clock and reset SHALL be as follows; the block has one clock, and reset is synchronous and active-high:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
REQ-006 Other ports SHALL be:
- start_sram  in  1  begin a load.
- n_coef_image  in  1  0 = coefficient load, 1 = image load.
- coef_select  in  7  coefficient set index.
- read_nxt_byte  in  1  timer pulse: fetch one byte.
- sram_done  in  1  timer pulse: load finished.
- sram_read_req  out  1  one-cycle SRAM read strobe.
- sram_addr  out  ADDR_W  SRAM byte address, valid with sram_read_req.
- sram_rdata  in  8  SRAM read data.
- sram_rdata_valid  in  1  sram_rdata is valid this cycle.
- word_out  out  32  packed bytes.
- word_valid  out  1  one-cycle qualifier for word_out.
- word_partial  out  1  word_out is zero-padded; valid with word_valid.
- bytes_loaded  out  10  bytes captured in the current load.
- busy  out  1  high in any state except IDLE.
- load_done  out  1  one-cycle completion pulse.
- err_overrun  out  1  sticky request-overrun flag.

Function
REQ-007 The FSM SHALL have the states IDLE, ARMED, WAIT, FLUSH and DONE.
REQ-008 In IDLE, start_sram SHALL latch the base address and enter ARMED; clear bytes_loaded, the lane counter and the packer; and clear err_overrun.
- If n_coef_image=0, base = COEF_BASE + coef_select*COEF_SET_BYTES, truncated to ADDR_W.
- If n_coef_image=1, base = IMAGE_BASE.
REQ-009 start_sram SHALL be ignored in every state except IDLE.
REQ-010 In ARMED, read_nxt_byte SHALL drive sram_read_req=1 with sram_addr=current address in the next cycle only, and the FSM SHALL enter WAIT.
REQ-011 In ARMED, sram_done SHALL enter FLUSH; if read_nxt_byte and sram_done occur together, the read SHALL be issued and done SHALL be deferred until after the data returns.
REQ-012 In WAIT, sram_rdata_valid SHALL:
- write sram_rdata into byte lane lane_cnt of the packer (lane 0 = bits 7:0, little-endian);
- increment the address, the lane counter (2 bits) and bytes_loaded;
- return the FSM to ARMED.
REQ-013 When lane 3 is written, word_valid SHALL pulse the following cycle with the full word and word_partial=0, and the packer SHALL clear.
REQ-014 read_nxt_byte while in WAIT SHALL be dropped and SHALL set err_overrun; err_overrun SHALL hold until rst or the next accepted start_sram.
REQ-015 sram_done while in WAIT SHALL set a pending-done flag; the FSM SHALL enter FLUSH on the cycle after sram_rdata_valid.
REQ-016 sram_rdata_valid outside WAIT SHALL be ignored.
REQ-017 In FLUSH, if lane_cnt!=0, word_valid SHALL pulse one cycle with the unwritten lanes zero and word_partial=1; the FSM SHALL then enter DONE. If lane_cnt==0, it SHALL enter DONE directly, with no word emitted.
REQ-018 DONE SHALL last one cycle, assert load_done=1 and return the FSM to IDLE; bytes_loaded SHALL hold until the next start_sram.
REQ-019 The address SHALL wrap from 2^ADDR_W-1 to 0, and bytes_loaded SHALL wrap from 1023 to 0; neither condition is an error.
REQ-020 Latency SHALL be:
- read_nxt_byte to sram_read_req: 1 cycle;
- sram_rdata_valid to the lane-3 word_valid: 1 cycle;
- sram_done to load_done: 2 cycles when idle in ARMED with lane_cnt==0, 3 cycles when a partial flush is needed.

Reset
REQ-021 rst SHALL force state=IDLE and SHALL clear all outputs, the address, the counters, the packer and the pending-done flag to 0 on the next clk edge, including when reset occurs mid-load.
REQ-022 After rst, a late sram_rdata_valid SHALL be ignored.

Structure
REQ-023 The state enum and the default base/size constants SHALL live in the shared project package ram_pkg, next to the other SRAM timing constants.
REQ-024 The block SHALL contain one natural sub-module, byte_packer (lane write, lane counter, word emit, flush), instantiated once; the FSM and the address counter SHALL stay in the top module.

Verification
REQ-025 Coefficient load: start_sram, n_coef_image=0, coef_select=3 -> first sram_addr=16'h0030.
REQ-026 Full word: 4 reads returning 8'h11, 22, 33, 44 -> word_out=32'h44332211, word_partial=0, bytes_loaded=4.
REQ-027 Partial flush: image load, 6 bytes then sram_done -> sram_addr starts 16'h4000; one full word, then a partial word 32'h0000_xxyy with word_partial=1; load_done pulses once.
REQ-028 Overrun and deferred done: read_nxt_byte issued, a second read_nxt_byte and sram_done asserted while in WAIT -> only one sram_read_req; err_overrun=1; FLUSH entered after the data returns.
REQ-029 Address wrap: IMAGE_BASE=16'hFFFE, 3 reads -> sram_addr sequence FFFE, FFFF, 0000.
REQ-030 Mid-operation reset: rst asserted in WAIT, then sram_rdata_valid arrives -> the FSM is in IDLE, all outputs 0, and no word is emitted.

Source files
------------

// File: rtl/ram_pkg.sv
// ram_pkg
// Shared SRAM definitions for the project.
// Contents:
//   - default SRAM byte-address width
//   - default coefficient/image base addresses and the coefficient set size
//   - loader FSM state encoding
//   - helper that turns a coefficient set index into a byte offset
package ram_pkg;

  localparam int unsigned SRAM_ADDR_W_DEFAULT    = 16;
  localparam logic [15:0] COEF_BASE_DEFAULT      = 16'h0000;
  localparam int unsigned COEF_SET_BYTES_DEFAULT = 16;
  localparam logic [15:0] IMAGE_BASE_DEFAULT     = 16'h4000;

  // Width of the per-load byte counter; it wraps silently at 1023.
  localparam int unsigned BYTES_LOADED_W = 10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_WAIT  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } loader_state_e;

  // Byte offset of coefficient set 'sel'. The caller truncates the result
  // to its own address width, so large products simply wrap.
  function automatic logic [31:0] coef_set_offset(input logic [6:0] sel,
                                                  input int unsigned set_bytes);
    return 32'(sel) * set_bytes;
  endfunction

endpackage

// File: rtl/sram_byte_loader_byte_packer.sv
// byte_packer
// Collects bytes into a little-endian 32-bit word and emits it when all four
// lanes are written, or zero-padded when a flush is requested.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   clear         drop any partially packed word and restart at lane 0
//   wr_en/wr_data write one byte into the current lane
//   flush         emit the partially packed word (ignored when lane_cnt==0)
//   lane_cnt      lane the next byte will be written into
//   word_out      last emitted word (held between emits)
//   word_valid    one-cycle qualifier for a newly emitted word
//   word_partial  emitted word was zero-padded; valid with word_valid
module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        wr_en,
  input  logic [7:0]  wr_data,
  input  logic        flush,
  output logic [1:0]  lane_cnt,
  output logic [31:0] word_out,
  output logic        word_valid,
  output logic        word_partial
);

  logic [31:0] acc_q, acc_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] word_out_q, word_out_d;
  logic        word_valid_q, word_valid_d;
  logic        word_partial_q, word_partial_d;

  // The accumulator is kept zero in unwritten lanes, so a flush can emit it
  // as-is and get the zero padding for free.
  always_comb begin
    acc_d          = acc_q;
    lane_d         = lane_q;
    word_out_d     = word_out_q;
    word_valid_d   = 1'b0;
    word_partial_d = 1'b0;

    if (clear) begin
      acc_d  = '0;
      lane_d = 2'd0;
    end else if (wr_en) begin
      if (lane_q == 2'd3) begin
        word_out_d     = {wr_data, acc_q[23:0]};
        word_valid_d   = 1'b1;
        word_partial_d = 1'b0;
        acc_d          = '0;
        lane_d         = 2'd0;
      end else begin
        acc_d[{lane_q, 3'b000} +: 8] = wr_data;
        lane_d                       = lane_q + 2'd1;
      end
    end else if (flush && (lane_q != 2'd0)) begin
      word_out_d     = acc_q;
      word_valid_d   = 1'b1;
      word_partial_d = 1'b1;
      acc_d          = '0;
      lane_d         = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q          <= '0;
      lane_q         <= 2'd0;
      word_out_q     <= '0;
      word_valid_q   <= 1'b0;
      word_partial_q <= 1'b0;
    end else begin
      acc_q          <= acc_d;
      lane_q         <= lane_d;
      word_out_q     <= word_out_d;
      word_valid_q   <= word_valid_d;
      word_partial_q <= word_partial_d;
    end
  end

  assign lane_cnt     = lane_q;
  assign word_out     = word_out_q;
  assign word_valid   = word_valid_q;
  assign word_partial = word_partial_q;

endmodule

// File: rtl/sram_byte_loader.sv
// sram_byte_loader
// Timer-paced SRAM byte fetcher: on start it latches a coefficient-set or
// image base address, issues one SRAM read per read_nxt_byte pulse, packs the
// returned bytes into 32-bit words and flushes a padded word when the timer
// signals the end of the load.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   start_sram          begin a load (only honoured in IDLE)
//   n_coef_image        0 = coefficient set coef_select, 1 = image
//   read_nxt_byte       fetch one byte
//   sram_done           load finished
//   sram_read_req/addr  one-cycle read strobe and its byte address
//   sram_rdata(_valid)  returned read data
//   word_out/valid/partial  packed word stream
//   bytes_loaded        bytes captured in the current load (wraps at 1023)
//   busy, load_done     status; load_done pulses once per load
//   err_overrun         sticky: a fetch request arrived while a read was open
module sram_byte_loader
  import ram_pkg::*;
#(
  parameter int unsigned        ADDR_W         = SRAM_ADDR_W_DEFAULT,
  parameter logic [ADDR_W-1:0]  COEF_BASE      = ADDR_W'(COEF_BASE_DEFAULT),
  parameter int unsigned        COEF_SET_BYTES = COEF_SET_BYTES_DEFAULT,
  parameter logic [ADDR_W-1:0]  IMAGE_BASE     = ADDR_W'(IMAGE_BASE_DEFAULT)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_sram,
  input  logic                      n_coef_image,
  input  logic [6:0]                coef_select,
  input  logic                      read_nxt_byte,
  input  logic                      sram_done,
  output logic                      sram_read_req,
  output logic [ADDR_W-1:0]         sram_addr,
  input  logic [7:0]                sram_rdata,
  input  logic                      sram_rdata_valid,
  output logic [31:0]               word_out,
  output logic                      word_valid,
  output logic                      word_partial,
  output logic [BYTES_LOADED_W-1:0] bytes_loaded,
  output logic                      busy,
  output logic                      load_done,
  output logic                      err_overrun
);

  loader_state_e             state_q, state_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic [ADDR_W-1:0]         sram_addr_q, sram_addr_d;
  logic                      sram_read_req_q, sram_read_req_d;
  logic [BYTES_LOADED_W-1:0] bytes_loaded_q, bytes_loaded_d;
  logic                      err_overrun_q, err_overrun_d;
  logic                      pending_done_q, pending_done_d;

  logic [ADDR_W-1:0] start_base;
  logic              pack_clear;
  logic              pack_wr;
  logic              pack_flush;
  logic [1:0]        lane_cnt;

  // Base address chosen at start; the coefficient offset wraps to ADDR_W.
  always_comb begin
    start_base = IMAGE_BASE;
    if (!n_coef_image) begin
      start_base = COEF_BASE + ADDR_W'(coef_set_offset(coef_select, COEF_SET_BYTES));
    end
  end

  // Next-state logic. A done that arrives while a read is outstanding is
  // parked in pending_done and honoured when the data comes back, so the
  // last byte always reaches the packer before the flush.
  // FLUSH stays for an extra cycle when a partial word exists: the packer
  // emits it on that edge and clears its lane counter, after which FLUSH
  // sees lane 0 and moves on to DONE.
  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    sram_addr_d     = '0;
    sram_read_req_d = 1'b0;
    bytes_loaded_d  = bytes_loaded_q;
    err_overrun_d   = err_overrun_q;
    pending_done_d  = pending_done_q;
    pack_clear      = 1'b0;
    pack_wr         = 1'b0;
    pack_flush      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_sram) begin
          addr_d         = start_base;
          bytes_loaded_d = '0;
          err_overrun_d  = 1'b0;
          pending_done_d = 1'b0;
          pack_clear     = 1'b1;
          state_d        = ST_ARMED;
        end
      end

      ST_ARMED: begin
        if (read_nxt_byte) begin
          sram_read_req_d = 1'b1;
          sram_addr_d     = addr_q;
          state_d         = ST_WAIT;
          if (sram_done) begin
            pending_done_d = 1'b1;
          end
        end else if (sram_done) begin
          state_d = ST_FLUSH;
        end
      end

      ST_WAIT: begin
        if (read_nxt_byte) begin
          err_overrun_d = 1'b1;
        end
        if (sram_done) begin
          pending_done_d = 1'b1;
        end
        if (sram_rdata_valid) begin
          pack_wr        = 1'b1;
          addr_d         = addr_q + 1'b1;
          bytes_loaded_d = bytes_loaded_q + 1'b1;
          if (pending_done_q || sram_done) begin
            pending_done_d = 1'b0;
            state_d        = ST_FLUSH;
          end else begin
            state_d = ST_ARMED;
          end
        end
      end

      ST_FLUSH: begin
        if (lane_cnt != 2'd0) begin
          pack_flush = 1'b1;
        end else begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      sram_addr_q     <= '0;
      sram_read_req_q <= 1'b0;
      bytes_loaded_q  <= '0;
      err_overrun_q   <= 1'b0;
      pending_done_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      sram_addr_q     <= sram_addr_d;
      sram_read_req_q <= sram_read_req_d;
      bytes_loaded_q  <= bytes_loaded_d;
      err_overrun_q   <= err_overrun_d;
      pending_done_q  <= pending_done_d;
    end
  end

  byte_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .clear        (pack_clear),
    .wr_en        (pack_wr),
    .wr_data      (sram_rdata),
    .flush        (pack_flush),
    .lane_cnt     (lane_cnt),
    .word_out     (word_out),
    .word_valid   (word_valid),
    .word_partial (word_partial)
  );

  assign sram_read_req = sram_read_req_q;
  assign sram_addr     = sram_addr_q;
  assign bytes_loaded  = bytes_loaded_q;
  assign err_overrun   = err_overrun_q;
  assign busy          = (state_q != ST_IDLE);
  assign load_done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_sram_byte_loader.sv
// tb_sram_byte_loader
// Drives whole loads into sram_byte_loader and compares the observed read
// addresses, packed words and status against a transaction-level model.
// A second instance with IMAGE_BASE=16'hFFFE shares the stimulus and is used
// for the address-wrap case.
module tb_sram_byte_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        startSram;
   logic        nCoefImage;
   logic [6:0]  coefSelect;
   logic        readNxtByte;
   logic        sramDone;
   logic [7:0]  sramRdata;
   logic        sramRdataValid;

   logic        sramReadReq;
   logic [15:0] sramAddr;
   logic [31:0] wordOut;
   logic        wordValid;
   logic        wordPartial;
   logic [9:0]  bytesLoaded;
   logic        busy;
   logic        loadDone;
   logic        errOverrun;

   logic        wReadReq;
   logic [15:0] wSramAddr;
   logic [31:0] wWordOut;
   logic        wWordValid;
   logic        wWordPartial;
   logic [9:0]  wBytesLoaded;
   logic        wBusy;
   logic        wLoadDone;
   logic        wErrOverrun;

   int checks = 0;
   int errors = 0;

   logic [7:0]  stimData[$];
   logic [15:0] obsAddr[$];
   logic [31:0] obsWord[$];
   logic        obsPartial[$];
   int          obsDone;
   logic [15:0] wrapAddr[$];

   typedef struct {
      bit          img;
      logic [6:0]  sel;
      int          nBytes;
      logic [15:0] expAddr0;
      logic [9:0]  expBytes;
      int          expWords;
      bit          expLastPartial;
   } vec_t;

   vec_t vecs[6];

   always #5 clk = ~clk;

   sram_byte_loader dut (
      .clk              (clk),
      .rst              (rst),
      .start_sram       (startSram),
      .n_coef_image     (nCoefImage),
      .coef_select      (coefSelect),
      .read_nxt_byte    (readNxtByte),
      .sram_done        (sramDone),
      .sram_read_req    (sramReadReq),
      .sram_addr        (sramAddr),
      .sram_rdata       (sramRdata),
      .sram_rdata_valid (sramRdataValid),
      .word_out         (wordOut),
      .word_valid       (wordValid),
      .word_partial     (wordPartial),
      .bytes_loaded     (bytesLoaded),
      .busy             (busy),
      .load_done        (loadDone),
      .err_overrun      (errOverrun)
   );

   sram_byte_loader #(.IMAGE_BASE(16'hFFFE)) dutWrap (
      .clk              (clk),
      .rst              (rst),
      .start_sram       (startSram),
      .n_coef_image     (nCoefImage),
      .coef_select      (coefSelect),
      .read_nxt_byte    (readNxtByte),
      .sram_done        (sramDone),
      .sram_read_req    (wReadReq),
      .sram_addr        (wSramAddr),
      .sram_rdata       (sramRdata),
      .sram_rdata_valid (sramRdataValid),
      .word_out         (wWordOut),
      .word_valid       (wWordValid),
      .word_partial     (wWordPartial),
      .bytes_loaded     (wBytesLoaded),
      .busy             (wBusy),
      .load_done        (wLoadDone),
      .err_overrun      (wErrOverrun)
   );

   // Outputs only change on posedge, so sampling on negedge is race-free.
   always @(negedge clk) begin
      if (sramReadReq) obsAddr.push_back(sramAddr);
      if (wordValid) begin
         obsWord.push_back(wordOut);
         obsPartial.push_back(wordPartial);
      end
      if (loadDone) obsDone++;
      if (wReadReq) wrapAddr.push_back(wSramAddr);
   end

   // Hard stop in case a wait loop is broken.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic clearObs();
      obsAddr.delete();
      obsWord.delete();
      obsPartial.delete();
      wrapAddr.delete();
      obsDone = 0;
   endtask

   function automatic logic [15:0] expBaseOf(input bit img, input logic [6:0] sel);
      if (img) return 16'h4000;
      return 16'(int'(sel) * 16);
   endfunction

   // Runs one complete load using the bytes in stimData.
   task automatic applyStimulus(input bit img, input logic [6:0] sel, input bit overrun,
                                input bit deferDone, input bit randTiming);
      int n;
      int lat;
      bit sawDone;
      n = stimData.size();
      clearObs();
      nCoefImage = img;
      coefSelect = sel;
      startSram  = 1'b1;
      tick();
      startSram  = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (randTiming) begin
            repeat ($urandom_range(0, 2)) begin
               startSram  = ($urandom_range(0, 3) == 0);
               nCoefImage = 1'($urandom);
               coefSelect = 7'($urandom);
               tick();
            end
            startSram = 1'b0;
         end
         readNxtByte = 1'b1;
         tick();
         readNxtByte = 1'b0;
         checkOutput("read_req_latency", 32'(sramReadReq), 32'd1);
         lat = randTiming ? int'($urandom_range(0, 3)) : 1;
         if ((overrun || (deferDone && i == n - 1)) && lat == 0) lat = 1;
         for (int k = 0; k < lat; k++) begin
            readNxtByte = overrun && (k == 0);
            sramDone    = deferDone && (i == n - 1) && (k == lat - 1);
            tick();
            readNxtByte = 1'b0;
            sramDone    = 1'b0;
         end
         sramRdata      = stimData[i];
         sramRdataValid = 1'b1;
         tick();
         sramRdataValid = 1'b0;
         sramRdata      = 8'($urandom);
         if (i % 4 == 3) checkOutput("word_valid_latency", 32'(wordValid), 32'd1);
      end
      if (!(deferDone && n > 0)) begin
         if (randTiming) repeat ($urandom_range(0, 2)) tick();
         sramDone = 1'b1;
         tick();
         sramDone = 1'b0;
      end
      sawDone = 1'b0;
      for (int c = 0; c < 20 && !sawDone; c++) begin
         if (loadDone) sawDone = 1'b1;
         else tick();
      end
      checkOutput("load_done_seen", 32'(sawDone), 32'd1);
      repeat (3) tick();
   endtask

   // Compares everything observed during the last load with the model.
   task automatic verifyLoad(input logic [15:0] base, input bit expOverrun);
      int n;
      int nWords;
      logic [31:0] w;
      logic [15:0] a;
      n = stimData.size();
      nWords = (n + 3) / 4;
      checkOutput("req_count", 32'(obsAddr.size()), 32'(n));
      for (int i = 0; i < n && i < obsAddr.size(); i++) begin
         a = base + 16'(i);
         checkOutput("req_addr", 32'(obsAddr[i]), 32'(a));
      end
      checkOutput("word_count", 32'(obsWord.size()), 32'(nWords));
      for (int wi = 0; wi < nWords && wi < obsWord.size(); wi++) begin
         w = 32'd0;
         for (int j = 0; j < 4; j++) begin
            if (wi * 4 + j < n) w = w | (32'(stimData[wi * 4 + j]) << (8 * j));
         end
         checkOutput("word_value", obsWord[wi], w);
         checkOutput("word_partial", 32'(obsPartial[wi]), 32'(wi * 4 + 4 > n));
      end
      checkOutput("load_done_count", 32'(obsDone), 32'd1);
      checkOutput("bytes_loaded", 32'(bytesLoaded), 32'(n % 1024));
      checkOutput("err_overrun", 32'(errOverrun), 32'(expOverrun));
      checkOutput("busy_after", 32'(busy), 32'd0);
   endtask

   task automatic measureDone(output int cyc);
      sramDone = 1'b1;
      tick();
      sramDone = 1'b0;
      cyc = 1;
      while (!loadDone && cyc < 10) begin
         tick();
         cyc++;
      end
   endtask

   initial begin
      int cyc;
      bit img;
      logic [6:0] sel;
      bit ovr;

      rst = 1'b1;
      startSram = 1'b0; nCoefImage = 1'b0; coefSelect = 7'd0;
      readNxtByte = 1'b0; sramDone = 1'b0; sramRdata = 8'h00; sramRdataValid = 1'b0;
      obsDone = 0;
      repeat (2) tick();

      // Reset state
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_read_req", 32'(sramReadReq), 32'd0);
      checkOutput("rst_addr", 32'(sramAddr), 32'd0);
      checkOutput("rst_word", wordOut, 32'd0);
      checkOutput("rst_word_valid", 32'(wordValid), 32'd0);
      checkOutput("rst_bytes", 32'(bytesLoaded), 32'd0);
      checkOutput("rst_load_done", 32'(loadDone), 32'd0);
      checkOutput("rst_err", 32'(errOverrun), 32'd0);
      rst = 1'b0;
      tick();

      // Table-driven loads: expected first address, counts and last flag
      vecs[0] = '{1'b0, 7'd0,   4, 16'h0000, 10'd4, 1, 1'b0};
      vecs[1] = '{1'b0, 7'd3,   2, 16'h0030, 10'd2, 1, 1'b1};
      vecs[2] = '{1'b0, 7'd127, 5, 16'h07F0, 10'd5, 2, 1'b1};
      vecs[3] = '{1'b1, 7'd9,   8, 16'h4000, 10'd8, 2, 1'b0};
      vecs[4] = '{1'b1, 7'd0,   0, 16'h4000, 10'd0, 0, 1'b0};
      vecs[5] = '{1'b0, 7'd64,  3, 16'h0400, 10'd3, 1, 1'b1};
      for (int v = 0; v < 6; v++) begin
         stimData.delete();
         for (int b = 0; b < vecs[v].nBytes; b++) stimData.push_back(8'($urandom));
         applyStimulus(vecs[v].img, vecs[v].sel, 1'b0, 1'b0, 1'b0);
         if (vecs[v].nBytes > 0 && obsAddr.size() > 0)
            checkOutput("tbl_addr0", 32'(obsAddr[0]), 32'(vecs[v].expAddr0));
         checkOutput("tbl_bytes", 32'(bytesLoaded), 32'(vecs[v].expBytes));
         checkOutput("tbl_words", 32'(obsWord.size()), 32'(vecs[v].expWords));
         if (vecs[v].expWords > 0 && obsPartial.size() > 0)
            checkOutput("tbl_last_partial", 32'(obsPartial[obsPartial.size() - 1]),
                        32'(vecs[v].expLastPartial));
         verifyLoad(expBaseOf(vecs[v].img, vecs[v].sel), 1'b0);
      end

      // Full word with known bytes
      stimData = '{8'h11, 8'h22, 8'h33, 8'h44};
      applyStimulus(1'b0, 7'd0, 1'b0, 1'b0, 1'b0);
      if (obsWord.size() > 0) checkOutput("full_word", obsWord[0], 32'h44332211);
      checkOutput("full_word_bytes", 32'(bytesLoaded), 32'd4);

      // Partial flush on image load of six bytes; also checks the wrap instance
      stimData = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
      applyStimulus(1'b1, 7'd0, 1'b0, 1'b0, 1'b0);
      if (obsAddr.size() > 0) checkOutput("img_addr0", 32'(obsAddr[0]), 32'h4000);
      if (obsWord.size() == 2) begin
         checkOutput("img_word0", obsWord[0], 32'h04030201);
         checkOutput("img_word1", obsWord[1], 32'h00000605);
         checkOutput("img_word1_partial", 32'(obsPartial[1]), 32'd1);
      end
      checkOutput("img_load_done_once", 32'(obsDone), 32'd1);
      checkOutput("wrap_count", 32'(wrapAddr.size()), 32'd6);
      if (wrapAddr.size() >= 3) begin
         checkOutput("wrap_addr0", 32'(wrapAddr[0]), 32'hFFFE);
         checkOutput("wrap_addr1", 32'(wrapAddr[1]), 32'hFFFF);
         checkOutput("wrap_addr2", 32'(wrapAddr[2]), 32'h0000);
      end

      // Done latency from ARMED with no partial word
      clearObs();
      nCoefImage = 1'b0; coefSelect = 7'd1; startSram = 1'b1; tick(); startSram = 1'b0;
      measureDone(cyc);
      checkOutput("done_latency_empty", 32'(cyc), 32'd2);
      checkOutput("done_empty_no_word", 32'(obsWord.size()), 32'd0);
      repeat (2) tick();

      // Done latency with one byte to flush
      clearObs();
      startSram = 1'b1; tick(); startSram = 1'b0;
      readNxtByte = 1'b1; tick(); readNxtByte = 0;
      sramRdata = 8'hA5; sramRdataValid = 1'b1; tick(); sramRdataValid = 1'b0;
      measureDone(cyc);
      checkOutput("done_latency_partial", 32'(cyc), 32'd3);
      if (obsWord.size() > 0) checkOutput("one_byte_word", obsWord[0], 32'h000000A5);
      repeat (2) tick();

      // Overrun and deferred done inside WAIT
      clearObs();
      startSram = 1'b1; tick(); startSram = 1'b0;
      readNxtByte = 1'b1; tick(); readNxtByte = 1'b0;
      readNxtByte = 1'b1; sramDone = 1'b1; tick(); readNxtByte = 1'b0; sramDone = 1'b0;
      checkOutput("ovr_no_second_req", 32'(sramReadReq), 32'd0);
      checkOutput("ovr_err", 32'(errOverrun), 32'd1);
      tick();
      checkOutput("ovr_still_busy", 32'(busy), 32'd1);
      checkOutput("ovr_no_early_done", 32'(loadDone), 32'd0);
      sramRdata = 8'h3C; sramRdataValid = 1'b1; tick(); sramRdataValid = 1'b0;
      checkOutput("defer_c1_no_word", 32'(wordValid), 32'd0);
      tick();
      checkOutput("defer_c2_word_valid", 32'(wordValid), 32'd1);
      checkOutput("defer_c2_partial", 32'(wordPartial), 32'd1);
      checkOutput("defer_c2_word", wordOut, 32'h0000003C);
      tick();
      checkOutput("defer_c3_done", 32'(loadDone), 32'd1);
      repeat (2) tick();
      checkOutput("ovr_req_count", 32'(obsAddr.size()), 32'd1);
      checkOutput("ovr_err_held", 32'(errOverrun), 32'd1);

      // Reset in WAIT followed by a late data return
      clearObs();
      startSram = 1'b1; tick(); startSram = 1'b0;
      readNxtByte = 1'b1; tick(); readNxtByte = 1'b0;
      rst = 1'b1; tick(); rst = 1'b0;
      checkOutput("mid_rst_busy", 32'(busy), 32'd0);
      checkOutput("mid_rst_req", 32'(sramReadReq), 32'd0);
      sramRdata = 8'h5A; sramRdataValid = 1'b1; tick(); sramRdataValid = 1'b0;
      repeat (3) tick();
      checkOutput("mid_rst_no_word", 32'(obsWord.size()), 32'd0);
      checkOutput("mid_rst_word_out", wordOut, 32'd0);
      checkOutput("mid_rst_bytes", 32'(bytesLoaded), 32'd0);
      checkOutput("mid_rst_err", 32'(errOverrun), 32'd0);
      checkOutput("mid_rst_busy_late", 32'(busy), 32'd0);
      checkOutput("mid_rst_done", 32'(loadDone), 32'd0);

      // bytes_loaded wrap past 1023
      stimData.delete();
      for (int b = 0; b < 1025; b++) stimData.push_back(8'($urandom));
      applyStimulus(1'b1, 7'd0, 1'b0, 1'b0, 1'b0);
      verifyLoad(16'h4000, 1'b0);

      // Randomized loads against the model
      for (int t = 0; t < 40; t++) begin
         img = 1'($urandom);
         sel = 7'($urandom);
         ovr = ($urandom_range(0, 3) == 0);
         stimData.delete();
         for (int b = 0; b < int'($urandom_range(0, 9)); b++) stimData.push_back(8'($urandom));
         applyStimulus(img, sel, ovr, ($urandom_range(0, 2) == 0), 1'b1);
         verifyLoad(expBaseOf(img, sel), ovr && (stimData.size() > 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
